// File: rtl/ftoi_pipe.sv
// Pipelined IEEE-754 single-precision to signed integer converter with
// selectable rounding, saturation, NaN flagging and valid/ready flow control.
module ftoi_pipe #(
    parameter int STAGES = 2,
    parameter int OUT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             x,
    input  logic                    rmode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf,
    output logic                    nan
);

    localparam int W = OUT_W + 25;
    localparam int D = (STAGES == 1) ? 1 : STAGES - 1;

    localparam logic [W-1:0]     ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     LIM_POS = {{26{1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [W-1:0]     LIM_NEG = LIM_POS + ONE;
    localparam logic [OUT_W-1:0] SMAX    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SMIN    = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic         s;
        logic         nan;
        logic         inf;
        logic         big;
        logic [W-1:0] mag;
    } mid_t;

    typedef struct packed {
        logic             ovf;
        logic             nan;
        logic [OUT_W-1:0] y;
    } res_t;

    // t = floor(2*|v|); rounding half away is then (t+1)>>1, truncation t>>1.
    function automatic mid_t f_round(input logic [31:0] xv, input logic rm);
        mid_t         r;
        logic [7:0]   e;
        logic [W-1:0] mant;
        logic [W-1:0] t;
        e     = xv[30:23];
        mant  = {{(W-24){1'b0}}, 1'b1, xv[22:0]};
        r.s   = xv[31];
        r.nan = (e == 8'hFF) && (xv[22:0] != 23'd0);
        r.inf = (e == 8'hFF) && (xv[22:0] == 23'd0);
        r.big = (e != 8'hFF) && (int'(e) >= 127 + OUT_W);
        if (e == 8'd0 || e == 8'hFF || r.big)
            t = '0;
        else if (e >= 8'd149)
            t = mant << (e - 8'd149);
        else
            t = mant >> (8'd149 - e);
        r.mag = rm ? (t >> 1) : ((t + ONE) >> 1);
        return r;
    endfunction

    // Range check is on the full-width rounded magnitude, asymmetric by sign.
    function automatic res_t f_sat(input mid_t m);
        res_t             r;
        logic             over;
        logic [OUT_W-1:0] mlo;
        mlo   = m.mag[OUT_W-1:0];
        over  = m.inf || m.big || (m.mag > (m.s ? LIM_NEG : LIM_POS));
        r.nan = m.nan;
        r.ovf = over && !m.nan;
        if (m.nan)
            r.y = SMAX;
        else if (over)
            r.y = m.s ? SMIN : SMAX;
        else
            r.y = m.s ? -mlo : mlo;
        return r;
    endfunction

    logic              stall;
    logic [STAGES-1:0] vld_q;
    res_t              res_d0;
    res_t              res_q [D];

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_q[STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Stage 1: decode + shift/round (merged with saturate when STAGES == 1)
    generate
        if (STAGES == 1) begin : g_one
            assign res_d0 = f_sat(f_round(x, rmode));
        end else begin : g_multi
            mid_t mid_p1_q;
            always_ff @(posedge clk) begin
                if (!stall) mid_p1_q <= f_round(x, rmode);
            end
            assign res_d0 = f_sat(mid_p1_q);
        end
    endgenerate

    // Stage 2: negate/saturate, followed by retiming-only delay stages
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < D; i++) res_q[i] <= '0;
        end else if (!stall) begin
            res_q[0] <= res_d0;
            for (int i = 1; i < D; i++) res_q[i] <= res_q[i-1];
        end
    end

    assign y   = res_q[D-1].y;
    assign ovf = res_q[D-1].ovf;
    assign nan = res_q[D-1].nan;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe (STAGES=2, OUT_W=32): directed vector table, backpressure,
// mid-flight reset and a random run against an integer reference model.
module tb_ftoi_pipe;

    localparam int STAGES = 2;
    localparam int OUT_W  = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        rmode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic        nan;

    ftoi_pipe #(.STAGES(STAGES), .OUT_W(OUT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .rmode(rmode), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .nan(nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        nan;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc;
    } sb_t;

    typedef struct {
        logic [31:0] x;
        logic        rm;
        logic [31:0] y;
        logic        ovf;
        logic        nan;
    } vec_t;

    sb_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Independent reference: integer part plus remainder-vs-half comparison.
    function automatic exp_t model(input logic [31:0] xv, input logic rm);
        exp_t            r;
        int              e;
        int              sh;
        longint unsigned mant, ip, rem, mag, lim;
        e     = int'(xv[30:23]);
        mant  = {40'd0, 1'b1, xv[22:0]};
        r.y   = 32'd0;
        r.ovf = 1'b0;
        r.nan = 1'b0;
        if (e == 255) begin
            if (xv[22:0] != 0) begin
                r.nan = 1'b1;
                r.y   = 32'h7FFF_FFFF;
            end else begin
                r.ovf = 1'b1;
                r.y   = xv[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            return r;
        end
        if (e == 0) return r;
        if (e - 127 >= 40) begin
            mag = 64'd1 << 40;
        end else if (e >= 150) begin
            mag = mant << (e - 150);
        end else begin
            sh  = 150 - e;
            ip  = (sh >= 40) ? 64'd0 : (mant >> sh);
            rem = (sh >= 40) ? mant : (mant - (ip << sh));
            if (!rm && sh <= 24 && rem >= (64'd1 << (sh - 1))) ip = ip + 1;
            mag = ip;
        end
        lim = xv[31] ? 64'h8000_0000 : 64'h7FFF_FFFF;
        if (mag > lim) begin
            r.ovf = 1'b1;
            r.y   = xv[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r.y = xv[31] ? (32'd0 - mag[31:0]) : mag[31:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out: got y=%0h with no result expected", y);
            end else begin
                sb_t s;
                s = q.pop_front();
                chk("y", y, s.e.y);
                chk("ovf", ovf, s.e.ovf);
                chk("nan", nan, s.e.nan);
                if (chk_lat) chk("latency", cyc - s.acc, STAGES);
            end
        end
    end

    task automatic send(input logic [31:0] xv, input logic rm, input exp_t ex);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        x        = xv;
        rmode    = rm;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                sb_t s;
                s.e   = ex;
                s.acc = cyc;
                q.push_back(s);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    vec_t        tbl [19];
    logic [31:0] bp_x [8];
    bit          done;
    int          bad;

    initial begin
        tbl[0]  = '{32'h3FC0_0000, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        tbl[1]  = '{32'h3FC0_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[2]  = '{32'hC020_0000, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0};
        tbl[3]  = '{32'hC020_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4]  = '{32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[5]  = '{32'hCF00_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
        tbl[6]  = '{32'h3F00_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        tbl[7]  = '{32'h3F00_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[8]  = '{32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9]  = '{32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[10] = '{32'h7F80_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[11] = '{32'hFF80_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0};
        tbl[12] = '{32'h0040_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[13] = '{32'hBF00_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[14] = '{32'h3EFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[15] = '{32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, 1'b0, 1'b0};
        tbl[16] = '{32'hCF00_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
        tbl[17] = '{32'h3F80_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[18] = '{32'h4049_0FDB, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        bp_x = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        x         = 32'd0;
        rmode     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_y", y, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_nan", nan, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Directed table, back-to-back with no stall
        chk_lat = 1'b1;
        for (int i = 0; i < 19; i++) begin
            exp_t ex;
            ex.y = tbl[i].y; ex.ovf = tbl[i].ovf; ex.nan = tbl[i].nan;
            send(tbl[i].x, tbl[i].rm, ex);
        end
        drain();
        chk_lat = 1'b0;

        // Backpressure: 5-cycle hold of out_ready in the middle of 8 operands
        fork
            begin
                for (int k = 0; k < 8; k++) send(bp_x[k], 1'b0, model(bp_x[k], 1'b0));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two conversions in flight
        chk_lat = 1'b1;
        send(32'h4110_0000, 1'b0, model(32'h4110_0000, 1'b0));
        send(32'h4120_0000, 1'b0, model(32'h4120_0000, 1'b0));
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("midrst_no_stale", bad, 0);
        @(posedge clk);
        #1;
        send(32'h3FC0_0000, 1'b0, model(32'h3FC0_0000, 1'b0));
        drain();
        chk_lat = 1'b0;

        // Random operands with random gaps and random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    logic [31:0] rv;
                    logic [7:0]  e8;
                    logic [31:0] xv;
                    logic        rm;
                    rv = $urandom();
                    if ($urandom_range(0, 9) == 0) e8 = $urandom_range(0, 1) ? 8'hFF : 8'h00;
                    else e8 = 8'($urandom_range(110, 165));
                    xv = {rv[31], e8, rv[22:0]};
                    rm = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(xv, rm, model(xv, rm));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
